mrr_pathway_merge: RTL and testbench

- Sits directly downstream of the MRR basic header block.
- Merges its per-pathway 32-bit decoded-packet AXI streams (o_tdata/o_tlast/o_tvalid/o_tkeep, one lane per decode pathway) into one host-bound stream.
- Arbitration is packet-atomic round-robin. Each forwarded packet is prefixed with one header word carrying the pathway index and a per-pathway sequence number.
- Output is fully registered, for timing toward the host DMA.

---
 rtl/mrr_pathway_merge_pkg.sv | 22 ++
 rtl/mrr_pathway_merge_rr_arbiter.sv | 36 +++
 rtl/mrr_pathway_merge.sv | 187 ++++++++++++++++++
 tb/tb_mrr_pathway_merge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrr_pathway_merge_pkg.sv
// mrr_pathway_merge_pkg
//   Shared definitions for the MRR pathway merge block:
//   header sync byte, header field positions and the merge FSM state type.
package mrr_pathway_merge_pkg;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  // Header word layout: [31:24] sync, [23:16] pathway, [15:0] sequence
  localparam int unsigned HDR_SYNC_MSB = 31;
  localparam int unsigned HDR_SYNC_LSB = 24;
  localparam int unsigned HDR_PW_MSB   = 23;
  localparam int unsigned HDR_PW_LSB   = 16;
  localparam int unsigned HDR_SEQ_MSB  = 15;
  localparam int unsigned HDR_SEQ_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } merge_state_e;

endpackage

// File: rtl/mrr_pathway_merge_rr_arbiter.sv
// mrr_rr_arbiter
//   Combinational round-robin picker. Searches req_i starting one above
//   last_grant_i with modular wrap; the first set bit wins.
// Ports:
//   req_i          requesting lanes
//   last_grant_i   lane granted most recently
//   grant_idx_o    selected lane (valid when grant_valid_o)
//   grant_valid_o  at least one lane requested
module mrr_rr_arbiter
  import mrr_pathway_merge_pkg::*;
#(
  parameter int unsigned NUM_PATHWAYS      = 4,
  parameter int unsigned NUM_PATHWAYS_LOG2 = 2
) (
  input  logic [NUM_PATHWAYS-1:0]      req_i,
  input  logic [NUM_PATHWAYS_LOG2-1:0] last_grant_i,
  output logic [NUM_PATHWAYS_LOG2-1:0] grant_idx_o,
  output logic                         grant_valid_o
);

  int unsigned idx;

  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    for (int unsigned i = 1; i <= NUM_PATHWAYS; i++) begin
      idx = (32'(last_grant_i) + i) % NUM_PATHWAYS;
      if (!grant_valid_o && req_i[NUM_PATHWAYS_LOG2'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = NUM_PATHWAYS_LOG2'(idx);
      end
    end
  end

endmodule

// File: rtl/mrr_pathway_merge.sv
// mrr_pathway_merge
//   Merges per-pathway 32-bit AXI streams into one host-bound stream with
//   packet-atomic round-robin arbitration. Each packet is prefixed with a
//   header word {A5, pathway, seq[pathway]}. Output is one registered stage.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pathway_enable        per-lane arbitration enable (sampled in IDLE only)
//   i_tdata/tkeep/tlast/tvalid/tready   per-lane input streams
//   o_tdata/tkeep/tlast/tuser/tvalid/tready  merged output stream
//   stat_pkt_count, stat_word_count     packet/word counters
// Build option:
//   MRR_MERGE_STATS_EN  when defined, enables the statistics counters;
//                       otherwise the stat ports are tied to 0.
module mrr_pathway_merge
  import mrr_pathway_merge_pkg::*;
#(
  parameter int unsigned NUM_PATHWAYS      = 4,
  parameter int unsigned NUM_PATHWAYS_LOG2 = 2,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned SEQ_WIDTH         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PATHWAYS-1:0]            pathway_enable,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tkeep,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic                               o_tkeep,
  output logic                               o_tlast,
  output logic [NUM_PATHWAYS_LOG2-1:0]       o_tuser,
  output logic                               o_tvalid,
  input  logic                               o_tready,
  output logic [31:0]                        stat_pkt_count,
  output logic [31:0]                        stat_word_count
);

  merge_state_e                 state_q, state_d;
  logic [NUM_PATHWAYS_LOG2-1:0] sel_q, sel_d;
  logic [NUM_PATHWAYS_LOG2-1:0] last_grant_q, last_grant_d;
  logic [SEQ_WIDTH-1:0]         seq_q [NUM_PATHWAYS];
  logic [SEQ_WIDTH-1:0]         seq_d [NUM_PATHWAYS];

  logic                         tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]        tdata_q, tdata_d;
  logic                         tkeep_q, tkeep_d;
  logic                         tlast_q, tlast_d;
  logic [NUM_PATHWAYS_LOG2-1:0] tuser_q, tuser_d;

  logic                         load_ok;
  logic [NUM_PATHWAYS-1:0]      arb_req;
  logic [NUM_PATHWAYS_LOG2-1:0] grant_idx;
  logic                         grant_valid;
  logic [DATA_WIDTH-1:0]        hdr_word;
  logic [DATA_WIDTH-1:0]        lane_data [NUM_PATHWAYS];

  for (genvar g = 0; g < NUM_PATHWAYS; g++) begin : g_lane
    assign lane_data[g] = i_tdata[DATA_WIDTH*g +: DATA_WIDTH];
  end

  assign load_ok = !tvalid_q || o_tready;
  assign arb_req = i_tvalid & pathway_enable;

  mrr_rr_arbiter #(
    .NUM_PATHWAYS      (NUM_PATHWAYS),
    .NUM_PATHWAYS_LOG2 (NUM_PATHWAYS_LOG2)
  ) u_arb (
    .req_i         (arb_req),
    .last_grant_i  (last_grant_q),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_SYNC_MSB:HDR_SYNC_LSB] = HDR_SYNC;
    hdr_word[HDR_PW_MSB:HDR_PW_LSB]     = 8'(sel_q);
    hdr_word[HDR_SEQ_MSB:HDR_SEQ_LSB]   = 16'(seq_q[sel_q]);
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    seq_d        = seq_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    i_tready     = '0;

    // A consumed (or empty) output slot drains unless refilled below.
    if (load_ok) tvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          sel_d   = grant_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        if (load_ok) begin
          tvalid_d = 1'b1;
          tdata_d  = hdr_word;
          tkeep_d  = 1'b1;
          tlast_d  = 1'b0;
          tuser_d  = sel_q;
          state_d  = DATA;
        end
      end
      DATA: begin
        i_tready[sel_q] = load_ok;
        if (load_ok && i_tvalid[sel_q]) begin
          tvalid_d = 1'b1;
          tdata_d  = lane_data[sel_q];
          tkeep_d  = i_tkeep[sel_q];
          tlast_d  = i_tlast[sel_q];
          tuser_d  = sel_q;
          if (i_tlast[sel_q]) begin
            seq_d[sel_q] = seq_q[sel_q] + SEQ_WIDTH'(1);
            last_grant_d = sel_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= NUM_PATHWAYS_LOG2'(NUM_PATHWAYS - 1);
      seq_q        <= '{default: '0};
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      seq_q        <= seq_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tdata  = tdata_q;
  assign o_tkeep  = tkeep_q;
  assign o_tlast  = tlast_q;
  assign o_tuser  = tuser_q;

`ifdef MRR_MERGE_STATS_EN
  logic        lane_fire;
  logic [31:0] stat_pkt_q, stat_word_q;

  assign lane_fire = (state_q == DATA) && load_ok && i_tvalid[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_q  <= '0;
      stat_word_q <= '0;
    end else if (lane_fire) begin
      stat_word_q <= stat_word_q + 32'd1;
      if (i_tlast[sel_q]) stat_pkt_q <= stat_pkt_q + 32'd1;
    end
  end

  assign stat_pkt_count  = stat_pkt_q;
  assign stat_word_count = stat_word_q;
`else
  assign stat_pkt_count  = '0;
  assign stat_word_count = '0;
`endif

endmodule

// File: tb/tb_mrr_pathway_merge.sv
module tb_mrr_pathway_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic         rst_n = 1'b0;
  logic [3:0]   pathway_enable = '0;
  logic [127:0] i_tdata = '0;
  logic [3:0]   i_tkeep = '0, i_tlast = '0, i_tvalid = '0, i_tready;
  logic [31:0]  o_tdata;
  logic         o_tkeep, o_tlast, o_tvalid;
  logic         o_tready = 1'b1;
  logic [1:0]   o_tuser;
  logic [31:0]  stat_pkt_count, stat_word_count;

  mrr_pathway_merge #(
    .NUM_PATHWAYS (4), .NUM_PATHWAYS_LOG2 (2), .DATA_WIDTH (32), .SEQ_WIDTH (16)
  ) dut (
    .clk (clk), .rst_n (rst_n), .pathway_enable (pathway_enable),
    .i_tdata (i_tdata), .i_tkeep (i_tkeep), .i_tlast (i_tlast),
    .i_tvalid (i_tvalid), .i_tready (i_tready),
    .o_tdata (o_tdata), .o_tkeep (o_tkeep), .o_tlast (o_tlast),
    .o_tuser (o_tuser), .o_tvalid (o_tvalid), .o_tready (o_tready),
    .stat_pkt_count (stat_pkt_count), .stat_word_count (stat_word_count)
  );

  // Narrow-sequence instance for the wrap check (3-bit seq wraps after 8)
  logic         rst2_n = 1'b0;
  logic [3:0]   en2 = 4'hF;
  logic [127:0] i_tdata2 = {96'h0, 32'h0000_0001};
  logic [3:0]   i_tkeep2 = 4'hF, i_tlast2 = 4'hF, i_tvalid2 = 4'b0001, i_tready2;
  logic [31:0]  o_tdata2;
  logic         o_tkeep2, o_tlast2, o_tvalid2;
  logic         o_tready2 = 1'b1;
  logic [1:0]   o_tuser2;
  logic [31:0]  stat_pkt2, stat_word2;

  mrr_pathway_merge #(
    .NUM_PATHWAYS (4), .NUM_PATHWAYS_LOG2 (2), .DATA_WIDTH (32), .SEQ_WIDTH (3)
  ) dut2 (
    .clk (clk), .rst_n (rst2_n), .pathway_enable (en2),
    .i_tdata (i_tdata2), .i_tkeep (i_tkeep2), .i_tlast (i_tlast2),
    .i_tvalid (i_tvalid2), .i_tready (i_tready2),
    .o_tdata (o_tdata2), .o_tkeep (o_tkeep2), .o_tlast (o_tlast2),
    .o_tuser (o_tuser2), .o_tvalid (o_tvalid2), .o_tready (o_tready2),
    .stat_pkt_count (stat_pkt2), .stat_word_count (stat_word2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lane sources: per-lane word FIFOs of {last, keep, data}
  logic [33:0] lane_mem [4][256];
  logic [7:0]  lane_wr [4] = '{default: '0};
  logic [7:0]  lane_rd [4] = '{default: '0};
  logic        flush_req = 1'b0;
  logic [3:0]  fire_n = '0;
  int          cyc = 0;
  int          rise_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 4; p++) begin
      logic [1:0]  l;
      logic [33:0] w;
      l = 2'(p);
      if (flush_req) lane_rd[l] = lane_wr[l];
      else if (fire_n[l]) lane_rd[l] = lane_rd[l] + 8'd1;
      if (lane_rd[l] != lane_wr[l]) begin
        if (!i_tvalid[l] && rise_cyc < 0) rise_cyc = cyc;
        w = lane_mem[l][lane_rd[l]];
        i_tvalid[l] = 1'b1;
        i_tlast[l]  = w[33];
        i_tkeep[l]  = w[32];
        i_tdata[32*p +: 32] = w[31:0];
      end else begin
        i_tvalid[l] = 1'b0;
        i_tlast[l]  = 1'b0;
        i_tkeep[l]  = 1'b0;
        i_tdata[32*p +: 32] = '0;
      end
    end
  end

  task automatic push(input int lane, input logic [31:0] d, input logic k, input logic last);
    logic [1:0] l;
    l = lane[1:0];
    lane_mem[l][lane_wr[l]] = {last, k, d};
    lane_wr[l] = lane_wr[l] + 8'd1;
  endtask

  // Output monitor and stall checks
  logic [35:0] out_mem [512];
  int          out_cyc [512];
  int          out_n = 0;
  logic        bp_chk = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev = '0;
  logic [17:0] hdr2 [64];
  int          hn2 = 0;
  int          nl2 = 0;

  always @(negedge clk) begin
    fire_n = i_tvalid & i_tready;
    if (rst_n && o_tvalid && o_tready) begin
      out_mem[out_n[8:0]] = {o_tuser, o_tlast, o_tkeep, o_tdata};
      out_cyc[out_n[8:0]] = cyc;
      out_n++;
    end
    if (bp_chk) begin
      if (stall_prev) begin
        check_eq("bp_hold_valid", 64'(o_tvalid), 64'd1);
        check_eq("bp_hold_data", 64'(o_tdata), 64'(data_prev));
      end
      if (o_tvalid && !o_tready) check_eq("bp_lane1_ready", 64'(i_tready[1]), 64'd0);
    end
    stall_prev = o_tvalid && !o_tready;
    data_prev  = o_tdata;
    if (rst2_n && o_tvalid2 && o_tready2) begin
      if (o_tkeep2 && !o_tlast2 && o_tdata2[31:24] == 8'hA5) begin
        hdr2[hn2[5:0]] = {o_tuser2, o_tdata2[15:0]};
        hn2++;
      end
      if (o_tlast2) nl2++;
    end
  end

  task automatic wait_out(input int n, input int budget);
    int c;
    c = 0;
    while (out_n < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (out_n < n) check_eq("wait_out_timeout", 64'(out_n), 64'(n));
  endtask

  task automatic expect_word(input int idx, input logic [1:0] u, input logic last,
                             input logic k, input logic [31:0] d);
    check_eq($sformatf("out_word%0d", idx), 64'(out_mem[idx[8:0]]), 64'({u, last, k, d}));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    flush_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    flush_req = 1'b0;
    out_n     = 0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("rst_o_tdata", 64'(o_tdata), 64'd0);
    check_eq("rst_o_tkeep", 64'(o_tkeep), 64'd0);
    check_eq("rst_o_tlast", 64'(o_tlast), 64'd0);
    check_eq("rst_o_tuser", 64'(o_tuser), 64'd0);
    check_eq("rst_i_tready", 64'(i_tready), 64'd0);
    check_eq("rst_stat_pkt", 64'(stat_pkt_count), 64'd0);
    check_eq("rst_stat_word", 64'(stat_word_count), 64'd0);
    rst_n = 1'b1;
    pathway_enable = 4'hF;

    // Single lane: lane 2, 3 words
    push(2, 32'h11, 1'b1, 1'b0);
    push(2, 32'h22, 1'b1, 1'b0);
    push(2, 32'h33, 1'b1, 1'b1);
    wait_out(4, 50);
    expect_word(0, 2'd2, 1'b0, 1'b1, 32'hA502_0000);
    expect_word(1, 2'd2, 1'b0, 1'b1, 32'h11);
    expect_word(2, 2'd2, 1'b0, 1'b1, 32'h22);
    expect_word(3, 2'd2, 1'b1, 1'b1, 32'h33);
    check_eq("hdr_latency", 64'(out_cyc[0] - rise_cyc), 64'd2);
    check_eq("data_latency", 64'(out_cyc[1] - rise_cyc), 64'd3);

    // Round-robin: every lane holds two 2-word packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) begin
        push(p, 32'h100 * p + 32'h10 * r + 32'h1, 1'b1, 1'b0);
        push(p, 32'h100 * p + 32'h10 * r + 32'h2, 1'b1, 1'b1);
      end
    wait_out(24, 300);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) begin
        int b;
        b = (r * 4 + p) * 3;
        expect_word(b,     2'(p), 1'b0, 1'b1, 32'hA500_0000 | (32'(p) << 16) | 32'(r));
        expect_word(b + 1, 2'(p), 1'b0, 1'b1, 32'h100 * p + 32'h10 * r + 32'h1);
        expect_word(b + 2, 2'(p), 1'b1, 1'b1, 32'h100 * p + 32'h10 * r + 32'h2);
      end

    // Backpressure: o_tready toggles during a 5-word packet on lane 1
    do_reset();
    for (int i = 1; i <= 5; i++) push(1, 32'h100 + 32'(i), 1'b1, (i == 5));
    bp_chk = 1'b1;
    for (int c = 0; c < 200 && out_n < 6; c++) begin
      @(posedge clk);
      #1;
      o_tready = ~o_tready;
    end
    o_tready = 1'b1;
    bp_chk   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_word_count", 64'(out_n), 64'd6);
    expect_word(0, 2'd1, 1'b0, 1'b1, 32'hA501_0000);
    for (int i = 1; i <= 5; i++) expect_word(i, 2'd1, (i == 5), 1'b1, 32'h100 + 32'(i));

    // Enable drop mid-packet on lane 3
    do_reset();
    for (int i = 1; i <= 4; i++) push(3, 32'h300 + 32'(i), 1'b1, (i == 4));
    push(3, 32'h3F1, 1'b1, 1'b1);
    wait_out(2, 50);
    pathway_enable = 4'b0111;
    push(1, 32'h1A1, 1'b0, 1'b1);
    wait_out(7, 100);
    repeat (10) @(posedge clk);
    #1;
    check_eq("en_word_count", 64'(out_n), 64'd7);
    check_eq("en_lane3_ready", 64'(i_tready[3]), 64'd0);
    expect_word(0, 2'd3, 1'b0, 1'b1, 32'hA503_0000);
    for (int i = 1; i <= 4; i++) expect_word(i, 2'd3, (i == 4), 1'b1, 32'h300 + 32'(i));
    expect_word(5, 2'd1, 1'b0, 1'b1, 32'hA501_0000);
    expect_word(6, 2'd1, 1'b1, 1'b0, 32'h1A1);

    // Reset mid-packet
    pathway_enable = 4'hF;
    do_reset();
    push(0, 32'h0A1, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) push(2, 32'h2B0 + 32'(i), 1'b1, (i == 6));
    wait_out(4, 60);
    expect_word(0, 2'd0, 1'b0, 1'b1, 32'hA500_0000);
    expect_word(2, 2'd2, 1'b0, 1'b1, 32'hA502_0000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("midrst_i_tready", 64'(i_tready), 64'd0);
    flush_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    flush_req = 1'b0;
    out_n = 0;
    push(3, 32'h3C1, 1'b1, 1'b1);
    push(0, 32'h0C1, 1'b1, 1'b1);
    rst_n = 1'b1;
    wait_out(4, 60);
    expect_word(0, 2'd0, 1'b0, 1'b1, 32'hA500_0000);
    expect_word(1, 2'd0, 1'b1, 1'b1, 32'h0C1);
    expect_word(2, 2'd3, 1'b0, 1'b1, 32'hA503_0000);
    expect_word(3, 2'd3, 1'b1, 1'b1, 32'h3C1);

    // Statistics: packets of 2, 1, 4 words
    do_reset();
    push(0, 32'hD01, 1'b1, 1'b0);
    push(0, 32'hD02, 1'b1, 1'b1);
    push(1, 32'hD11, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) push(2, 32'hD20 + 32'(i), 1'b1, (i == 4));
    wait_out(10, 100);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stat_out_count", 64'(out_n), 64'd10);
`ifdef MRR_MERGE_STATS_EN
    check_eq("stat_pkt", 64'(stat_pkt_count), 64'd3);
    check_eq("stat_word", 64'(stat_word_count), 64'd7);
`else
    check_eq("stat_pkt_tied", 64'(stat_pkt_count), 64'd0);
    check_eq("stat_word_tied", 64'(stat_word_count), 64'd0);
`endif

    // Sequence wrap on the narrow-sequence instance
    @(posedge clk);
    #2;
    rst2_n = 1'b1;
    for (int c = 0; c < 100 && hn2 < 10; c++) @(posedge clk);
    #1;
    i_tvalid2 = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    if (hn2 < 10) check_eq("wrap_hdr_timeout", 64'(hn2), 64'd10);
    check_eq("wrap_hdr0", 64'(hdr2[0]), 64'h0);
    check_eq("wrap_hdr7", 64'(hdr2[7]), 64'h0007);
    check_eq("wrap_hdr8", 64'(hdr2[8]), 64'h0000);
    check_eq("wrap_hdr9", 64'(hdr2[9]), 64'h0001);
    check_eq("wrap_other_ready", 64'(i_tready2 & 4'b1110), 64'd0);
`ifdef MRR_MERGE_STATS_EN
    check_eq("wrap_stat_pkt", 64'(stat_pkt2), 64'(nl2));
    check_eq("wrap_stat_word", 64'(stat_word2), 64'(nl2));
`else
    check_eq("wrap_stat_pkt_tied", 64'(stat_pkt2), 64'd0);
    check_eq("wrap_stat_word_tied", 64'(stat_word2), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
